// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   group_def    : default number of bits resolved per pipeline stage
//   stage_count  : pipeline depth for a given operand width and slice width
package pipelined_cla_addsub_pkg;

  localparam int GROUP_DEF = 4;

  function automatic int stage_count(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/pipelined_cla_addsub_cla_group.sv
// Purely combinational GROUP-bit carry-lookahead slice.
// Ports:
//   a, b   : slice operands (b already conditioned for subtraction)
//   cin    : carry into bit 0 of the slice
//   sum    : slice sum
//   cout   : carry out of the top bit of the slice
//   c_msb  : carry into the top bit of the slice (used for signed overflow)
module pipelined_cla_addsub_cla_group
  import pipelined_cla_addsub_pkg::*;
#(
  parameter int GROUP = GROUP_DEF
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             prop;

  // Every carry is a flat sum of products over g/p and cin, so no carry
  // depends on another carry inside the slice.
  always_comb begin
    // NOTE: every variable gets a value on every path first, otherwise the
    // tool infers a latch to remember the old value.
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    prop = 1'b0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      prop   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prop & g[j]);
        prop   = prop & p[j];
      end
      c[i+1] = c[i+1] | (prop & cin);
    end
  end

  assign sum   = p ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit slice per stage.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand handshake; a beat transfers when both are 1
//   a, b, cin, sub       : operands; sub=1 computes a-b (cin ignored)
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : result, carry out of MSB (no-borrow when sub=1),
//                          signed overflow
// Latency is STAGES cycles; throughput is one beat per cycle.
module pipelined_cla_addsub
  import pipelined_cla_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = GROUP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stage_count(WIDTH, GROUP);

  if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_params
    $error("pipelined_cla_addsub: WIDTH (%0d) must be a non-zero multiple of GROUP (%0d)",
           WIDTH, GROUP);
  end

  // Inputs seen by stage k: from the ports for k=0, from register k-1 above.
  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in, s_next;
  logic [STAGES-1:0]            c_in, v_in;

  // Pipeline registers: stage k holds the beat after slice k is resolved.
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic [STAGES-1:0]            c_q, v_q, cmsb_q;

  logic [STAGES-1:0][GROUP-1:0] slice_sum;
  logic [STAGES-1:0]            slice_cout, slice_cmsb;

  logic advance;

  assign out_valid = v_q[STAGES-1];
  // The whole pipe moves as one shift register; bubbles move with it.
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  always_comb begin
    a_in    = '0;
    b_in    = '0;
    s_in    = '0;
    c_in    = '0;
    v_in    = '0;
    // Subtraction is a + ~b + 1, so the borrow-free case yields cout=1.
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    c_in[0] = sub ? 1'b1 : cin;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    pipelined_cla_addsub_cla_group #(.GROUP(GROUP)) u_cla (
      .a     (a_in[k][k*GROUP +: GROUP]),
      .b     (b_in[k][k*GROUP +: GROUP]),
      .cin   (c_in[k]),
      .sum   (slice_sum[k]),
      .cout  (slice_cout[k]),
      .c_msb (slice_cmsb[k])
    );
  end

  // Lower slices pass through untouched; slice k is filled in at stage k.
  always_comb begin
    s_next = s_in;
    for (int k = 0; k < STAGES; k++) begin
      s_next[k][k*GROUP +: GROUP] = slice_sum[k];
    end
  end

  // NOTE: every pipeline register, data included, is reset so that a reset
  // mid-operation can never expose a partial or stale result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      c_q    <= '0;
      cmsb_q <= '0;
    end else if (advance) begin
      // NOTE: non-blocking assignments so every stage samples the values its
      // neighbour held before this edge, independent of statement order.
      v_q    <= v_in;
      a_q    <= a_in;
      b_q    <= b_in;
      s_q    <= s_next;
      c_q    <= slice_cout;
      cmsb_q <= slice_cmsb;
    end
  end

  assign sum  = s_q[STAGES-1];
  assign cout = c_q[STAGES-1];
  assign ovf  = cmsb_q[STAGES-1] ^ c_q[STAGES-1];

  // Operand bits and intermediate carry-into-MSB values that reach the tail
  // of the pipeline with no further consumer.
  logic unused_bits;
  assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], a_in[STAGES-1],
                         b_in[STAGES-1], cmsb_q};

endmodule
